// File: rtl/mips_cpu_harvard_lsu_if.sv
// Bundle of the CPU-side request/response signals and the Harvard
// data-memory port seen by the load/store unit.
//   slave  : the load/store unit's view (takes CPU requests, drives memory)
//   master : the environment's view (CPU datapath plus data memory)
interface mips_cpu_harvard_lsu_if;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_done;
  logic        cpu_fault;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_size, cpu_signed, cpu_writedata,
    output cpu_readdata, cpu_done, cpu_fault,
    output data_address, data_read, data_write, data_writedata,
    input  data_readdata
  );

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_size, cpu_signed, cpu_writedata,
    input  cpu_readdata, cpu_done, cpu_fault,
    input  data_address, data_read, data_write, data_writedata,
    output data_readdata
  );
endinterface

// File: rtl/mips_cpu_harvard_lsu.sv
// Load/store unit between the CPU datapath and the Harvard data-memory port.
// Turns byte/halfword/word accesses into aligned 32-bit word accesses,
// using read-modify-write for sub-word stores and sign/zero extension for
// sub-word loads. Byte order is big-endian.
// Optional feature macro: MIPS_LSU_ALIGN_CHECK_EN -- when defined, misaligned,
// illegal-size and read+write requests are rejected with cpu_fault and never
// touch memory; when undefined, cpu_fault stays 0 and such requests are
// folded onto legal accesses.
module mips_cpu_harvard_lsu (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_cpu_harvard_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        isLoad_q;
  logic [31:0] wdata_q;

  logic [31:0] cpuReaddata_q;
  logic        cpuDone_q;
  logic        cpuFault_q;
  logic [31:0] dataAddress_q;
  logic        dataRead_q;
  logic        dataWrite_q;
  logic [31:0] dataWritedata_q;

  logic        reqFault;
  logic        reqLoad;
  logic        reqWord;

  // Pick the addressed byte/half out of a big-endian word and extend it
  function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of the fetched word with right-justified store data
  function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    res[31:24] = wdata[7:0];
          2'd1:    res[23:16] = wdata[7:0];
          2'd2:    res[15:8]  = wdata[7:0];
          default: res[7:0]   = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) res[15:0]  = wdata[15:0];
        else         res[31:16] = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Classify the incoming request: rejected, load, or whole-word access
  always_comb begin
    reqFault = 1'b0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    reqFault = (bus.cpu_size == 2'b11) ||
               ((bus.cpu_size == 2'b01) && bus.cpu_address[0]) ||
               ((bus.cpu_size == 2'b10) && (bus.cpu_address[1:0] != 2'b00)) ||
               (bus.cpu_read && bus.cpu_write);
`endif
    reqLoad = bus.cpu_read;
    reqWord = bus.cpu_size[1];
  end

  // Access sequencer: latches the request in IDLE and walks RD/WR/RESP with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      lane_q          <= 2'd0;
      size_q          <= 2'd0;
      signed_q        <= 1'b0;
      isLoad_q        <= 1'b0;
      wdata_q         <= 32'd0;
      cpuReaddata_q   <= 32'd0;
      cpuDone_q       <= 1'b0;
      cpuFault_q      <= 1'b0;
      dataAddress_q   <= 32'd0;
      dataRead_q      <= 1'b0;
      dataWrite_q     <= 1'b0;
      dataWritedata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_read || bus.cpu_write) begin
            lane_q   <= bus.cpu_address[1:0];
            size_q   <= bus.cpu_size;
            signed_q <= bus.cpu_signed;
            isLoad_q <= reqLoad;
            wdata_q  <= bus.cpu_writedata;
            if (reqFault) begin
              state_q       <= RESP;
              cpuDone_q     <= 1'b1;
              cpuFault_q    <= 1'b1;
              cpuReaddata_q <= 32'd0;
            end else if (reqLoad || !reqWord) begin
              state_q       <= RD;
              dataRead_q    <= 1'b1;
              dataAddress_q <= {bus.cpu_address[31:2], 2'b00};
            end else begin
              state_q         <= WR;
              dataWrite_q     <= 1'b1;
              dataAddress_q   <= {bus.cpu_address[31:2], 2'b00};
              dataWritedata_q <= bus.cpu_writedata;
            end
          end
        end
        RD: begin
          dataRead_q <= 1'b0;
          if (isLoad_q) begin
            state_q       <= RESP;
            cpuDone_q     <= 1'b1;
            cpuFault_q    <= 1'b0;
            cpuReaddata_q <= extractLoad(bus.data_readdata, lane_q, size_q, signed_q);
          end else begin
            state_q         <= WR;
            dataWrite_q     <= 1'b1;
            dataWritedata_q <= mergeStore(bus.data_readdata, wdata_q, lane_q, size_q);
          end
        end
        WR: begin
          state_q       <= RESP;
          dataWrite_q   <= 1'b0;
          cpuDone_q     <= 1'b1;
          cpuFault_q    <= 1'b0;
          cpuReaddata_q <= 32'd0;
        end
        default: begin
          state_q       <= IDLE;
          cpuDone_q     <= 1'b0;
          cpuFault_q    <= 1'b0;
          cpuReaddata_q <= 32'd0;
        end
      endcase
    end
  end

  assign bus.cpu_readdata   = cpuReaddata_q;
  assign bus.cpu_done       = cpuDone_q;
  assign bus.cpu_fault      = cpuFault_q;
  assign bus.data_address   = dataAddress_q;
  assign bus.data_read      = dataRead_q;
  assign bus.data_write     = dataWrite_q;
  assign bus.data_writedata = dataWritedata_q;

endmodule

// File: tb/tb_mips_cpu_harvard_lsu.sv
// Bench for mips_cpu_harvard_lsu: a small word memory at 0x1000..0x103F sits
// on the data port, a byte-array reference model predicts every response, and
// a monitor compares completions against a queue of expected responses.
module tb_mips_cpu_harvard_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          reads;
    int          writes;
    int          start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycleCnt = 0;
  int   total = 0;
  int   bad = 0;
  int   curReads = 0;
  int   curWrites = 0;

  logic [31:0] tbMem [0:15];
  logic [7:0]  refBytes [0:63];
  exp_t        expQ [$];

  logic [31:0] lastRdata;
  logic        lastFault;
  logic [31:0] lastWdata;

  mips_cpu_harvard_lsu_if bus();

  mips_cpu_harvard_lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure request-to-done latency
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Combinational-read, synchronous-write data memory
  assign bus.data_readdata = tbMem[bus.data_address[5:2]];

  always @(posedge clk) begin
    if (bus.data_write) tbMem[bus.data_address[5:2]] <= bus.data_writedata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] refWord(input int i);
    return {refBytes[4*i], refBytes[4*i+1], refBytes[4*i+2], refBytes[4*i+3]};
  endfunction

  // Reference model: memory as a big-endian byte array
  task automatic modelRequest(input logic [31:0] addr, input logic rd, input logic wr,
                              input logic [1:0] size, input logic sgn,
                              input logic [31:0] wdata, output exp_t e);
    logic        fault;
    int          nb;
    int          off;
    logic [31:0] val;
    fault = 1'b0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    fault = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'd0) || (rd && wr);
`endif
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr - 32'h1000);
    off = off - (off % nb);
    e.rdata = 32'd0;
    e.fault = fault;
    e.start = 0;
    if (fault) begin
      e.lat = 2; e.reads = 0; e.writes = 0;
    end else if (rd) begin
      val = 32'd0;
      for (int i = 0; i < nb; i++) val = (val << 8) | {24'd0, refBytes[off+i]};
      if (sgn && nb < 4 && val[8*nb-1]) val = val - (32'd1 << (8*nb));
      e.rdata = val;
      e.lat = 3; e.reads = 1; e.writes = 0;
    end else begin
      for (int i = 0; i < nb; i++) refBytes[off+i] = 8'(wdata >> (8*(nb-1-i)));
      e.lat    = (nb == 4) ? 3 : 4;
      e.reads  = (nb == 4) ? 0 : 1;
      e.writes = 1;
    end
  endtask

  // Issue one request, hold it until done (bounded), then drop it
  task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
    exp_t e;
    int   waited;
    bit   seen;
    modelRequest(addr, rd, wr, size, sgn, wdata, e);
    e.start = cycleCnt;
    expQ.push_back(e);
    bus.cpu_address   = addr;
    bus.cpu_read      = rd;
    bus.cpu_write     = wr;
    bus.cpu_size      = size;
    bus.cpu_signed    = sgn;
    bus.cpu_writedata = wdata;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (bus.data_write) lastWdata = bus.data_writedata;
      if (bus.cpu_done) begin
        seen      = 1'b1;
        lastRdata = bus.cpu_readdata;
        lastFault = bus.cpu_fault;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL doneTimeout: got no cpu_done expected cpu_done within 20 cycles (addr 0x%08h)", addr);
      expQ.delete();
    end
    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  // Monitor: protocol checks every cycle, scoreboard compare on each completion
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.data_read || bus.data_write) begin
        checkOutput("strobeExclusive", {31'd0, bus.data_read & bus.data_write}, 32'd0);
        checkOutput("addrAligned", {30'd0, bus.data_address[1:0]}, 32'd0);
      end
      if (bus.data_read)  curReads++;
      if (bus.data_write) curWrites++;
      if (bus.cpu_done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("readdata", bus.cpu_readdata, e.rdata);
          checkOutput("fault", {31'd0, bus.cpu_fault}, {31'd0, e.fault});
          checkOutput("latency", 32'(cycleCnt - e.start + 1), 32'(e.lat));
          checkOutput("readStrobes", 32'(curReads), 32'(e.reads));
          checkOutput("writeStrobes", 32'(curWrites), 32'(e.writes));
        end
        curReads  = 0;
        curWrites = 0;
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] addr;
    logic [1:0]  size;
    int          op;
    bus.cpu_address   = 32'd0;
    bus.cpu_read      = 1'b0;
    bus.cpu_write     = 1'b0;
    bus.cpu_size      = 2'd0;
    bus.cpu_signed    = 1'b0;
    bus.cpu_writedata = 32'd0;
    lastRdata = 32'd0;
    lastFault = 1'b0;
    lastWdata = 32'd0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      if (i == 0) w = 32'hCAFEF00D;
      if (i == 1) w = 32'h8899AABB;
      tbMem[i] <= w;
      refBytes[4*i]   = w[31:24];
      refBytes[4*i+1] = w[23:16];
      refBytes[4*i+2] = w[15:8];
      refBytes[4*i+3] = w[7:0];
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReaddata", bus.cpu_readdata, 32'd0);
    checkOutput("rstDone", {31'd0, bus.cpu_done}, 32'd0);
    checkOutput("rstFault", {31'd0, bus.cpu_fault}, 32'd0);
    checkOutput("rstDataAddress", bus.data_address, 32'd0);
    checkOutput("rstDataRead", {31'd0, bus.data_read}, 32'd0);
    checkOutput("rstDataWrite", {31'd0, bus.data_write}, 32'd0);
    checkOutput("rstDataWritedata", bus.data_writedata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed loads and stores");
    applyStimulus(32'h1005, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0);
    checkOutput("tpSignedByte", lastRdata, 32'hFFFFFF99);
    applyStimulus(32'h1006, 1'b1, 1'b0, 2'b01, 1'b0, 32'd0);
    checkOutput("tpUnsignedHalf", lastRdata, 32'h0000AABB);
    applyStimulus(32'h1004, 1'b1, 1'b0, 2'b01, 1'b1, 32'd0);
    checkOutput("tpSignedHalf", lastRdata, 32'hFFFF8899);
    applyStimulus(32'h1007, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000005A);
    checkOutput("tpRmwWritedata", lastWdata, 32'h8899AA5A);
    applyStimulus(32'h1004, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0);
    checkOutput("tpAfterByteStore", lastRdata, 32'h8899AA5A);
    applyStimulus(32'h1008, 1'b0, 1'b1, 2'b10, 1'b0, 32'h12345678);
    applyStimulus(32'h1008, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0);
    checkOutput("tpAfterWordStore", lastRdata, 32'h12345678);
    applyStimulus(32'h1002, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    checkOutput("tpMisalignedFault", {31'd0, lastFault}, 32'd1);
`else
    checkOutput("tpMisalignedWord", lastRdata, 32'hCAFEF00D);
`endif

    $display("[TB] reset during read of a read-modify-write");
    bus.cpu_address   = 32'h1004;
    bus.cpu_read      = 1'b0;
    bus.cpu_write     = 1'b1;
    bus.cpu_size      = 2'b01;
    bus.cpu_signed    = 1'b0;
    bus.cpu_writedata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    checkOutput("rmwReadStrobe", {31'd0, bus.data_read}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortReaddata", bus.cpu_readdata, 32'd0);
    checkOutput("abortAddress", bus.data_address, 32'd0);
    checkOutput("abortWritedata", bus.data_writedata, 32'd0);
    checkOutput("abortFlags", {28'd0, bus.cpu_done, bus.cpu_fault, bus.data_read, bus.data_write}, 32'd0);
    bus.cpu_write = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    curReads  = 0;
    curWrites = 0;
    checkOutput("abortMemUnchanged", tbMem[1], refWord(1));
    @(posedge clk);
    #1;
    applyStimulus(32'h1004, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0);
    checkOutput("afterAbortLoad", lastRdata, 32'h8899AA5A);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 80; n++) begin
      op   = int'($urandom_range(0, 9));
      addr = 32'h1000 + 32'($urandom_range(0, 63));
      size = 2'($urandom_range(0, 3));
      applyStimulus(addr, op < 5 || op == 9, op >= 5, size, 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("mem%0d", i), tbMem[i], refWord(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_harvard_lsu.md
# mips_cpu_harvard_lsu

Load/store unit between the CPU datapath and the Harvard data-memory port. It turns byte, halfword and word loads and stores into aligned 32-bit word accesses. Sub-word stores become read-modify-write sequences, and loads are sign- or zero-extended. It is a small FSM with a hold-until-done handshake toward the CPU, and it drives the combinational-read, synchronous-write data memory at base 0x00001000.

## Interface
- No parameters. Big-endian byte order is fixed.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cpu_address` input 32: byte address of the request.
- `cpu_read` input 1: load request; held until `cpu_done`.
- `cpu_write` input 1: store request; held until `cpu_done`.
- `cpu_size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `cpu_signed` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `cpu_writedata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `cpu_readdata` output 32: extended load result; valid while `cpu_done`=1.
- `cpu_done` output 1: one-cycle completion pulse.
- `cpu_fault` output 1: high with `cpu_done` when the request was rejected.
- `data_address` output 32: word-aligned address (bits [1:0]=0).
- `data_read` output 1: memory read strobe.
- `data_write` output 1: memory write strobe.
- `data_writedata` output 32: full word to write.
- `data_readdata` input 32: memory read data, combinational from `data_address`.

## Operation
- FSM states are IDLE, RD, WR and RESP.
- **IDLE**:
  - When `cpu_read`|`cpu_write` is high, latch address, size, signed and writedata.
  - Fault request (see Configuration): go to RESP with fault flag set; no memory access.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- **RD**:
  - `data_read`=1, `data_address`={addr[31:2],2'b00}.
  - Capture `data_readdata` at the edge.
  - Load: go to RESP.
  - Sub-word store: go to WR.
- **WR**:
  - `data_write`=1.
  - `data_writedata` = full store word, or the captured word with the selected lane replaced.
  - Go to RESP.
- **RESP**:
  - `cpu_done`=1, `cpu_fault`=fault flag, `cpu_readdata` = extended load data (0 for stores and faults).
  - Go to IDLE.
- **Byte lanes (big-endian)**:
  - Byte at addr[1:0]=0 uses bits [31:24]; 1 uses [23:16]; 2 uses [15:8]; 3 uses [7:0].
  - Half at addr[1]=0 uses [31:16]; addr[1]=1 uses [15:0].
- **Extension**: sign-extend from bit 7/15 when `cpu_signed`=1, else zero-fill. Word loads are unmodified.
- `data_read` and `data_write` are never high in the same cycle.
- `data_address` and `data_writedata` hold their last value outside RD/WR.

## Timing
- Cycle 1 is the first cycle the request is high.
- Word load: RD in cycle 2, `cpu_done` in cycle 3.
- Word store: WR in cycle 2 (memory updated at end of cycle 2), `cpu_done` in cycle 3.
- Sub-word load: `cpu_done` in cycle 3.
- Sub-word store: RD cycle 2, WR cycle 3, `cpu_done` cycle 4.
- Fault: `cpu_done`=`cpu_fault`=1 in cycle 2.
- CPU must drop or change its request in the cycle after `cpu_done`. A request still high in IDLE starts a new access.
- Request inputs are ignored outside IDLE; latched values are used.
- Reset values: state IDLE; `cpu_readdata`=0, `cpu_done`=0, `cpu_fault`=0, `data_address`=0, `data_read`=0, `data_write`=0, `data_writedata`=0.
- Reset in any state aborts immediately. Reset during RD of an RMW means no write occurs. Reset during WR drops the strobe asynchronously, so the write is not guaranteed.

## Configuration
- Macro `MIPS_LSU_ALIGN_CHECK_EN`.
- **Defined**: each of these faults and gets no memory access:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - `cpu_size`=11;
  - `cpu_read` and `cpu_write` both high.
- **Undefined**:
  - `cpu_fault` is tied 0.
  - Misaligned low address bits are ignored: half uses addr[1]; word uses lane 0.
  - `cpu_size`=11 is treated as word.
  - Both read and write high is treated as a load.

## Test plan
- Preload word 0x1004=0x8899AABB; signed byte load 0x1005 → `cpu_done` cycle 3, `cpu_readdata`=0xFFFFFF99.
- Unsigned half load 0x1006 from the same word → 0x0000AABB; signed half load 0x1004 → 0xFFFF8899.
- Byte store 0x0000005A to 0x1007 → RD cycle 2, WR cycle 3 with `data_writedata`=0x8899AA5A, `cpu_done` cycle 4; a read of 0x1004 returns 0x8899AA5A.
- Word store 0x12345678 to 0x1008 → single `data_write` cycle 2, no `data_read`, `cpu_done` cycle 3; a word load returns 0x12345678.
- With macro: word load 0x1002 → `cpu_done`=`cpu_fault`=1 in cycle 2, `data_read`/`data_write` never high. Without macro: same access returns the word at 0x1000, no fault.
- Halfword store to 0x1004, `rst_n` pulsed low during RD → outputs all 0 immediately, no `data_write`, memory word unchanged, next request serviced normally.
